// File: rtl/din_syn_capture.sv
// Oversampling receiver for the serial CLOCK/DATA/SYNC stream; deserialises one frame per sync pulse.
// Define DIN_SYN_CMP_EN to build the expected-data comparator (exp_data, mismatch, first_err_idx).
module din_syn_capture #(
    parameter int unsigned MAX_BITS = 1024,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                ser_clk,
    input  logic                ser_din,
    input  logic                ser_syn,
    input  logic [CNT_W-1:0]    exp_length,
    input  logic                rx_ack,
`ifdef DIN_SYN_CMP_EN
    input  logic [MAX_BITS-1:0] exp_data,
    output logic                mismatch,
    output logic [CNT_W-1:0]    first_err_idx,
`endif
    output logic [MAX_BITS-1:0] rx_data,
    output logic [CNT_W-1:0]    rx_length,
    output logic                rx_valid,
    output logic                len_err,
    output logic                overflow,
    output logic                timeout,
    output logic                busy
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    // Input conditioning: 2-FF synchronisers, history FFs, registered edge pulses.
    logic [2:0] meta_d, meta_q, sync_d, sync_q;
    logic       clk_hist_d, clk_hist_q, syn_hist_d, syn_hist_q;
    logic       clk_rise_d, clk_rise_q, syn_rise_d, syn_rise_q, din_smp_d, din_smp_q;

    always_comb begin
        meta_d     = {ser_syn, ser_din, ser_clk};
        sync_d     = meta_q;
        clk_hist_d = sync_q[0];
        syn_hist_d = sync_q[2];
        clk_rise_d = sync_q[0] & ~clk_hist_q;
        syn_rise_d = sync_q[2] & ~syn_hist_q;
        din_smp_d  = sync_q[1];
    end

    state_e              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [TMR_W-1:0]    tmr_d, tmr_q;
    logic [MAX_BITS-1:0] rx_shift_d, rx_shift_q;
    logic [MAX_BITS-1:0] rx_data_d, rx_data_q;
    logic [CNT_W-1:0]    rx_length_d, rx_length_q;
    logic                len_err_d, len_err_q;
    logic                overflow_d, overflow_q;
    logic                timeout_d, timeout_q;
    logic                hold_enter;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_length_d = rx_length_q;
        len_err_d   = len_err_q;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;
        hold_enter  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clk_rise_q) begin
                    rx_shift_d[0] = din_smp_q;
                    cnt_d         = CNT_W'(1);
                    tmr_d         = '0;
                    state_d       = StShift;
                end
            end
            StShift: begin
                // Sync wins over a coincident clock edge; that bit is dropped.
                if (syn_rise_q) begin
                    rx_data_d   = rx_shift_q;
                    rx_length_d = cnt_q;
                    len_err_d   = (cnt_q != exp_length);
                    hold_enter  = 1'b1;
                    state_d     = StHold;
                end else if (clk_rise_q) begin
                    tmr_d = '0;
                    if (32'(cnt_q) < MAX_BITS) begin
                        rx_shift_d[IDX_W'(cnt_q)] = din_smp_q;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmr_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            StHold: begin
                if (rx_ack) begin
                    len_err_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta_q      <= '0;
            sync_q      <= '0;
            clk_hist_q  <= 1'b0;
            syn_hist_q  <= 1'b0;
            clk_rise_q  <= 1'b0;
            syn_rise_q  <= 1'b0;
            din_smp_q   <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            tmr_q       <= '0;
            rx_data_q   <= '0;
            rx_length_q <= '0;
            len_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            clk_hist_q  <= clk_hist_d;
            syn_hist_q  <= syn_hist_d;
            clk_rise_q  <= clk_rise_d;
            syn_rise_q  <= syn_rise_d;
            din_smp_q   <= din_smp_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            rx_data_q   <= rx_data_d;
            rx_length_q <= rx_length_d;
            len_err_q   <= len_err_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    // Bits at or above cnt are stale by design, so the shift register needs no reset.
    always_ff @(posedge clk_in) begin
        rx_shift_q <= rx_shift_d;
    end

    assign rx_data   = rx_data_q;
    assign rx_length = rx_length_q;
    assign rx_valid  = (state_q == StHold);
    assign len_err   = len_err_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q == StShift);

`ifdef DIN_SYN_CMP_EN
    logic             cmp_pend_d, cmp_pend_q;
    logic             mismatch_d, mismatch_q;
    logic [CNT_W-1:0] first_err_idx_d, first_err_idx_q;
    logic             cmp_hit;
    logic [CNT_W-1:0] cmp_idx;

    // Scan downwards so the lowest differing index is the one that sticks.
    always_comb begin
        cmp_hit = 1'b0;
        cmp_idx = '0;
        for (int i = int'(MAX_BITS) - 1; i >= 0; i--) begin
            if ((i < int'(32'(rx_length_q))) && (rx_data_q[i] != exp_data[i])) begin
                cmp_hit = 1'b1;
                cmp_idx = CNT_W'(i);
            end
        end
    end

    always_comb begin
        cmp_pend_d      = hold_enter;
        mismatch_d      = mismatch_q;
        first_err_idx_d = first_err_idx_q;
        if (rx_valid && rx_ack) begin
            cmp_pend_d      = 1'b0;
            mismatch_d      = 1'b0;
            first_err_idx_d = '0;
        end else if (cmp_pend_q) begin
            mismatch_d      = cmp_hit;
            first_err_idx_d = cmp_idx;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cmp_pend_q      <= 1'b0;
            mismatch_q      <= 1'b0;
            first_err_idx_q <= '0;
        end else begin
            cmp_pend_q      <= cmp_pend_d;
            mismatch_q      <= mismatch_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

    assign mismatch      = mismatch_q;
    assign first_err_idx = first_err_idx_q;
`else
    logic unused_hold_enter;
    assign unused_hold_enter = hold_enter;
`endif

endmodule

// File: tb/tb_din_syn_capture.sv
// Bench for din_syn_capture: table of frames through a scoreboard, plus overflow, timeout,
// mid-frame reset, coincident sync/clock and (with DIN_SYN_CMP_EN) comparator sequences.
module tb_din_syn_capture;

    localparam int unsigned MB = 512;
    localparam int unsigned CW = 10;
    localparam int unsigned TO = 64;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst = 1'b1, ser_clk = 1'b0, ser_din = 1'b0, ser_syn = 1'b0, rx_ack = 1'b0;
    logic [CW-1:0] exp_length = '0;
    logic [MB-1:0] rx_data;
    logic [CW-1:0] rx_length;
    logic          rx_valid, len_err, overflow, timeout, busy;
    logic [7:0]    s_rx_data;
    logic [CW-1:0] s_rx_length;
    logic          s_rx_valid, s_len_err, s_overflow, s_timeout, s_busy;
`ifdef DIN_SYN_CMP_EN
    logic [MB-1:0] exp_data = '0;
    logic          mismatch, s_mismatch;
    logic [CW-1:0] first_err_idx, s_first_err_idx;
`endif

    din_syn_capture #(.MAX_BITS(MB), .CNT_W(CW), .TIMEOUT(TO)) u_dut (
        .clk_in(clk_in), .rst(rst), .ser_clk(ser_clk), .ser_din(ser_din), .ser_syn(ser_syn),
        .exp_length(exp_length), .rx_ack(rx_ack),
`ifdef DIN_SYN_CMP_EN
        .exp_data(exp_data), .mismatch(mismatch), .first_err_idx(first_err_idx),
`endif
        .rx_data(rx_data), .rx_length(rx_length), .rx_valid(rx_valid), .len_err(len_err),
        .overflow(overflow), .timeout(timeout), .busy(busy)
    );

    din_syn_capture #(.MAX_BITS(8), .CNT_W(CW), .TIMEOUT(TO)) u_small (
        .clk_in(clk_in), .rst(rst), .ser_clk(ser_clk), .ser_din(ser_din), .ser_syn(ser_syn),
        .exp_length(exp_length), .rx_ack(rx_ack),
`ifdef DIN_SYN_CMP_EN
        .exp_data(exp_data[7:0]), .mismatch(s_mismatch), .first_err_idx(s_first_err_idx),
`endif
        .rx_data(s_rx_data), .rx_length(s_rx_length), .rx_valid(s_rx_valid),
        .len_err(s_len_err), .overflow(s_overflow), .timeout(s_timeout), .busy(s_busy)
    );

    typedef struct {
        int            len;
        logic          err;
        logic [MB-1:0] data;
    } exp_t;

    typedef struct {
        string         name;
        int            nbits;
        logic [MB-1:0] sent;
        logic [CW-1:0] el;
        int            want_len;
        logic          want_err;
        logic [MB-1:0] want_data;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ser_clk = 1'b0; ser_din = 1'b0; ser_syn = 1'b0; rx_ack = 1'b0; rst = 1'b1;
        repeat (4) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    // Serial clock is clk_in/8; data changes with the falling serial edge.
    task automatic send_bit(input logic b);
        ser_din = b; ser_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        ser_clk = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic run_frame(input string name, input int n, input logic [MB-1:0] sent,
                             input logic [CW-1:0] el, input logic simul, input int want_len,
                             input logic want_err, input logic [MB-1:0] want_data);
        exp_t          e;
        int            lat;
        logic [MB-1:0] mask;
        e.len = want_len; e.err = want_err; e.data = want_data;
        sb_q.push_back(e);
        exp_length = el;
        for (int i = 0; i < n; i++) send_bit(sent[i]);
        ser_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        if (simul) ser_clk = 1'b1;
        ser_syn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (rx_valid) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, lat, 4);
        e = sb_q.pop_front();
        mask = (e.len >= int'(MB)) ? '1 : ((MB'(1) << e.len) - MB'(1));
        check({name, " rx_length"}, rx_length, e.len);
        check({name, " len_err"}, len_err, e.err);
        check({name, " rx_data"}, rx_data & mask, e.data & mask);
        check({name, " busy"}, busy, 1'b0);
        @(negedge clk_in);
        ser_syn = 1'b0;
    endtask

    task automatic do_ack(input string name);
        rx_ack = 1'b1;
        @(posedge clk_in); #1;
        check({name, " ack clears rx_valid/len_err"}, {rx_valid, len_err}, 2'b00);
        @(negedge clk_in);
        rx_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[5];
        logic [7:0]  pat;
        logic [11:0] w;
        logic [31:0] r;
        logic [4:0]  five;
        pat  = 8'hA5;
        w    = 12'hABC;
        r    = $urandom;
        five = 5'b10110;

        vecs[0] = '{"match451", 451, '0, 10'd451, 451, 1'b0, {64{8'hA5}}};
        for (int i = 0; i < 451; i++) vecs[0].sent[i] = pat[i % 8];
        vecs[1] = '{"short12", 12, '0, 10'd16, 12, 1'b1, MB'(12'h3D5)};
        for (int i = 0; i < 12; i++) vecs[1].sent[i] = w[11 - i];
        vecs[2] = '{"rand32", 32, MB'(r), 10'd32, 32, 1'b0, MB'(r)};
        vecs[3] = '{"single", 1, MB'(1), 10'd2, 1, 1'b1, MB'(1)};
        vecs[4] = '{"nine", 9, MB'(9'h1B3), 10'd9, 9, 1'b0, MB'(9'h1B3)};

        do_reset();
        check("reset flags", {rx_valid, len_err, overflow, timeout, busy, rx_length}, '0);
        check("reset rx_data", rx_data, '0);

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].name, vecs[v].nbits, vecs[v].sent, vecs[v].el, 1'b0,
                      vecs[v].want_len, vecs[v].want_err, vecs[v].want_data);
            check({vecs[v].name, " overflow"}, overflow, 1'b0);
            do_ack(vecs[v].name);
        end

        // Sync with no bits received is ignored.
        ser_syn = 1'b1;
        repeat (10) @(negedge clk_in);
        check("lone sync ignored", {rx_valid, busy}, 2'b00);
        ser_syn = 1'b0;
        repeat (3) @(negedge clk_in);

        // Overflow on the 8-bit instance; sticky through ack, cleared by rst.
        do_reset();
        run_frame("ovf", 10, MB'(10'h2E9), 10'd10, 1'b0, 10, 1'b0, MB'(10'h2E9));
        check("ovf small valid/overflow", {s_rx_valid, s_overflow}, 2'b11);
        check("ovf small rx_length", s_rx_length, 10);
        check("ovf small rx_data", s_rx_data, 8'hE9);
        check("ovf wide overflow", overflow, 1'b0);
        do_ack("ovf");
        check("ovf sticky after ack", {s_rx_valid, s_overflow}, 2'b01);
        do_reset();
        check("ovf cleared by rst", s_overflow, 1'b0);

        // Timeout: five bits then a stalled serial clock.
        for (int i = 0; i < 5; i++) send_bit(five[i]);
        ser_clk = 1'b0;
        repeat (100) @(negedge clk_in);
        check("timeout flags", {timeout, busy, rx_valid}, 3'b100);
        check("timeout small", s_timeout, 1'b1);
        run_frame("post-timeout", 8, MB'(8'h5C), 10'd8, 1'b0, 8, 1'b0, MB'(8'h5C));
        do_ack("post-timeout");
        check("timeout sticky", timeout, 1'b1);

        // Reset three bits into a frame.
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("mid-frame busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk_in); #1;
        check("mid-frame rst busy", busy, 1'b0);
        check("mid-frame rst flags", {rx_valid, len_err, overflow, timeout, rx_length}, '0);
        check("mid-frame rst rx_data", rx_data, '0);
        @(negedge clk_in);
        ser_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);

        // Sync and clock rising together: that bit is dropped.
        run_frame("simul", 4, MB'(4'b1011), 10'd4, 1'b1, 4, 1'b0, MB'(4'b1011));
        do_ack("simul");

`ifdef DIN_SYN_CMP_EN
        exp_data = MB'(8'hFF);
        run_frame("cmp", 8, MB'(8'hF7), 10'd8, 1'b0, 8, 1'b0, MB'(8'hF7));
        @(posedge clk_in); #1;
        check("cmp mismatch", mismatch, 1'b1);
        check("cmp first_err_idx", first_err_idx, 3);
        check("cmp small", {s_mismatch, s_first_err_idx}, {1'b1, 10'd3});
        @(negedge clk_in);
        do_ack("cmp");
        check("cmp cleared", {mismatch, first_err_idx}, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/din_syn_capture.md
Name: din_syn_capture

Overview:
- Receive-side counterpart of the clk/dout/syn pattern generator on the DE0 GPIO header.
- Oversamples the serial CLOCK/DATA/SYNC lines on the board clock and deserialises the bits into a parallel capture register.
- On the sync pulse, presents the captured word and its bit count to the host logic (vJTAG readback or loopback checker).
- Used to verify the generator in loopback and to read back chip scan chains.

Parameters:
- MAX_BITS, 1024, capture register width; matches the generator's data register width.
- CNT_W, 10, width of the bit counter and length fields.
- TIMEOUT, 4096, clk_in cycles without a serial clock edge before a frame in progress is aborted.

Ports:
- clk_in  input  1  board clock. Must be at least 4x the serial clock rate.
- rst  input  1  synchronous, active-high reset.
- ser_clk  input  1  serial CLOCK from GPIO; asynchronous.
- ser_din  input  1  serial DATA from GPIO; asynchronous.
- ser_syn  input  1  serial SYNC from GPIO; asynchronous.
- exp_length  input  CNT_W  expected number of bits per frame.
- rx_ack  input  1  host acknowledges the presented frame.
- rx_data  output  MAX_BITS  captured frame; bit i is the i-th received bit.
- rx_length  output  CNT_W  number of bits received in the frame.
- rx_valid  output  1  frame available; held until acknowledged.
- len_err  output  1  rx_length differs from exp_length (qualified by rx_valid).
- overflow  output  1  sticky; more than MAX_BITS clock edges were seen in one frame.
- timeout  output  1  sticky; a frame was aborted because the serial clock stopped.
- busy  output  1  a frame is in progress.

Behaviour:
- Interface fixed: one clock, clk_in. Reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, shift counter 0, synchronisers cleared.
- Input conditioning:
  - ser_clk, ser_din and ser_syn each pass through a 2-FF synchroniser plus one history FF.
  - clk_rise = sync & ~hist on the clock line. syn_rise is formed the same way on the sync line.
  - Data is sampled from the synchronised ser_din in the cycle clk_rise is detected. The generator changes data on the falling edge of its clock, so data is stable at the rising edge.
- State machine (IDLE, SHIFT, HOLD):
  - IDLE:
    - clk_rise: write bit to rx_shift[0], set cnt=1, go to SHIFT, busy=1.
    - syn_rise with no bits received: ignored.
  - SHIFT:
    - clk_rise: if cnt<MAX_BITS, write rx_shift[cnt]=bit. Then cnt=cnt+1, saturating at 2^CNT_W-1. If cnt>=MAX_BITS, set overflow and discard the bit.
    - Each clk_rise clears the idle timer. Otherwise the timer increments.
    - syn_rise (takes precedence over a simultaneous clk_rise, whose bit is dropped):
      - copy rx_shift to rx_data and cnt to rx_length;
      - len_err = (cnt != exp_length);
      - rx_valid=1, busy=0, go to HOLD.
    - timer == TIMEOUT-1: set timeout, clear cnt, go to IDLE. rx_data is unchanged.
  - HOLD:
    - Holds outputs until rx_ack. At rx_ack: rx_valid=0, len_err=0, cnt=0, go to IDLE.
    - Serial edges arriving in HOLD are dropped.
    - rx_ack while rx_valid=0 has no effect.
- Latency: rx_valid rises 4 clk_in cycles after the ser_syn rising edge at the pin (2 sync + 1 edge + 1 register).
- rx_shift bits at index >= cnt keep stale values. rx_data bits at index >= rx_length are don't-care.
- overflow and timeout clear only on rst.
- rst mid-frame: the frame is discarded and state returns to IDLE in the next cycle.

Optional Feature:
- Macro: DIN_SYN_CMP_EN.
- When defined:
  - Adds input exp_data[MAX_BITS] and outputs mismatch (1b) and first_err_idx (CNT_W).
  - In the cycle rx_valid rises, compare rx_data[0..rx_length-1] against exp_data, registered one cycle later.
  - mismatch=1 if any bit differs. first_err_idx = lowest differing index, else 0.
  - Both outputs clear on rx_ack.
- When undefined: these ports do not exist and no comparator logic is built.

Test Plan:
- Length match: exp_length=451; send 451 bits of pattern 0xA5 repeated, serial clock = clk_in/8, then a sync pulse -> rx_valid=1, rx_length=451, len_err=0, rx_data[450:0] equals the pattern. After rx_ack, rx_valid=0 next cycle.
- Length mismatch: exp_length=16; send 12 bits 0xABC then sync -> rx_length=12, len_err=1, rx_data[11:0]=12'h3D5 (bit 0 received first).
- Overflow: MAX_BITS=8; send 10 edges then sync -> overflow=1, rx_length=10, rx_data[7:0] = first 8 bits. overflow stays 1 after rx_ack until rst.
- Timeout: TIMEOUT=64; send 5 bits then hold the clock low for 100 cycles -> timeout=1, busy=0, rx_valid stays 0. The next full frame captures normally.
- Reset mid-frame and simultaneous events: assert rst after 3 bits -> next cycle busy=0 and all outputs 0. Sync and clock rising together -> the bit is dropped and rx_length excludes it.
- DIN_SYN_CMP_EN defined: exp_data=0xFF, send 8 bits 0xF7 -> mismatch=1, first_err_idx=3.
